// File: rtl/banco_registradores_wb_if.sv
// Bus bundle for the write-back register file: write-back request, source data,
// the two read ports and the status outputs.
interface banco_registradores_wb_if #(
    parameter int LARGURA  = 32,
    parameter int ENDERECO = 5
);
    logic                escreveReg;
    logic [1:0]          origEscrita;
    logic [ENDERECO-1:0] regDestino;
    logic [LARGURA-1:0]  resultadoULA;
    logic [LARGURA-1:0]  dadoMemoria;
    logic [LARGURA-1:0]  pcMais1;
    logic [LARGURA-1:0]  dadoEntrada;
    logic [ENDERECO-1:0] regLeitura1;
    logic [ENDERECO-1:0] regLeitura2;
    logic [LARGURA-1:0]  dado1;
    logic [LARGURA-1:0]  dado2;
    logic                pendente;
    logic [15:0]         escritas;

    modport master (
        output escreveReg, origEscrita, regDestino, resultadoULA, dadoMemoria,
               pcMais1, dadoEntrada, regLeitura1, regLeitura2,
        input  dado1, dado2, pendente, escritas
    );

    modport slave (
        input  escreveReg, origEscrita, regDestino, resultadoULA, dadoMemoria,
               pcMais1, dadoEntrada, regLeitura1, regLeitura2,
        output dado1, dado2, pendente, escritas
    );
endinterface

// File: rtl/banco_registradores_wb.sv
// Register file with a one-entry write-back stage: a sampled request is held for
// one cycle, forwarded to both read ports, then committed to the array.
module banco_registradores_wb #(
    parameter int LARGURA  = 32,
    parameter int ENDERECO = 5
) (
    input logic                     clock,
    input logic                     reset,
    banco_registradores_wb_if.slave bus
);
    localparam int NREG = 1 << ENDERECO;

    logic [LARGURA-1:0]  array_q [NREG];
    logic [LARGURA-1:0]  array_d [NREG];
    logic [ENDERECO-1:0] pend_end_q, pend_end_d;
    logic [LARGURA-1:0]  pend_valor_q, pend_valor_d;
    logic                pendente_q, pendente_d;
    logic [15:0]         escritas_q, escritas_d;
    logic [LARGURA-1:0]  valor;
    logic                aceita;

    always_comb begin
        valor = '0;
        unique case (bus.origEscrita)
            2'b00:   valor = bus.resultadoULA;
            2'b01:   valor = bus.dadoMemoria;
            2'b10:   valor = bus.pcMais1;
            default: valor = bus.dadoEntrada;
        endcase
    end

    // Requests to register 0 are dropped entirely: no load, no commit, no count.
    assign aceita = bus.escreveReg && (bus.regDestino != '0);

    always_comb begin
        array_d      = array_q;
        escritas_d   = escritas_q;
        pend_end_d   = pend_end_q;
        pend_valor_d = pend_valor_q;
        pendente_d   = aceita;
        if (pendente_q) begin
            array_d[pend_end_q] = pend_valor_q;
            escritas_d          = escritas_q + 16'd1;
        end
        array_d[0] = '0;
        if (aceita) begin
            pend_end_d   = bus.regDestino;
            pend_valor_d = valor;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            array_q      <= '{default: '0};
            pend_end_q   <= '0;
            pend_valor_q <= '0;
            pendente_q   <= 1'b0;
            escritas_q   <= '0;
        end else begin
            array_q      <= array_d;
            pend_end_q   <= pend_end_d;
            pend_valor_q <= pend_valor_d;
            pendente_q   <= pendente_d;
            escritas_q   <= escritas_d;
        end
    end

    // Pending entry wins over the array so a just-sampled write is visible at once.
    function automatic logic [LARGURA-1:0] leitura(input logic [ENDERECO-1:0] endereco);
        if (endereco == '0)
            return '0;
        else if (pendente_q && (endereco == pend_end_q))
            return pend_valor_q;
        else
            return array_q[endereco];
    endfunction

    assign bus.dado1    = leitura(bus.regLeitura1);
    assign bus.dado2    = leitura(bus.regLeitura2);
    assign bus.pendente = pendente_q;
    assign bus.escritas = escritas_q;
endmodule
